// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared encodings and helpers for the data-memory responder
package data_mem_responder_pkg;

    // Access size encodings (size 2'b11 is served as a word)
    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    // Direction encodings
    localparam logic MEM_RW_LOAD  = 1'b0;
    localparam logic MEM_RW_STORE = 1'b1;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } mem_state_t;

    // Index of the last byte of an access: k-1 for k = 1/2/4 bytes
    function automatic logic [1:0] size_last_idx(input logic [1:0] size);
        case (size)
            MEM_SIZE_BYTE: size_last_idx = 2'd0;
            MEM_SIZE_HALF: size_last_idx = 2'd1;
            default:       size_last_idx = 2'd3;
        endcase
    endfunction

    // Halfwords need addr[0]=0, words (and size 11) need addr[1:0]=0
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            MEM_SIZE_BYTE: is_misaligned = 1'b0;
            MEM_SIZE_HALF: is_misaligned = addr_lo[0];
            default:       is_misaligned = |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_byte_array.sv
// rtl/data_mem_responder_byte_array.sv - single-port byte array, synchronous write, asynchronous read
module data_mem_byte_array #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wr_data,
    output logic [7:0]        rd_data
);

    // Contents are deliberately not reset; the bench preloads through this array
    logic [7:0] Mem [DEPTH];

    // One byte written per enabled cycle
    always_ff @(posedge clk) begin
        if (wr_en) begin
            Mem[addr] <= wr_data;
        end
    end

    assign rd_data = Mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle byte-serial data-memory responder (option: DATA_MEM_ALIGN_CHECK_EN)
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        Req_Enable,
    input  logic        Req_RW,
    input  logic [1:0]  Req_Size,
    input  logic [31:0] Req_Addr,
    input  logic [31:0] Req_Data,
    output logic [31:0] Rsp_Data,
    output logic        Rsp_Busy,
    output logic        Rsp_Done,
    output logic        Rsp_Error
);

    mem_state_t        state;
    logic [1:0]        byte_cnt;
    logic [1:0]        last_idx;
    logic [ADDR_W-1:0] base_addr;
    logic              rw_q;
    logic [31:0]       st_data;
    logic [31:0]       asm_data;

    logic [ADDR_W-1:0] cur_addr;
    logic [1:0]        shift_idx;
    logic [7:0]        wr_byte;
    logic [7:0]        rd_byte;
    logic              wr_en;
    logic              last_byte;

    // Address bits above the array size are intentionally ignored
    logic unused_addr_hi;
    assign unused_addr_hi = ^Req_Addr[31:ADDR_W];

    // Byte i of an access lives at base+i, wrapping at the top of the array
    assign cur_addr  = base_addr + ADDR_W'(byte_cnt);
    assign last_byte = (byte_cnt == last_idx);

    // Big-endian: byte 0 is the most-significant byte of the right-justified store data
    assign shift_idx = last_idx - byte_cnt;
    assign wr_byte   = st_data[{shift_idx, 3'b000} +: 8];

    // A reset on the same edge suppresses the pending byte write
    assign wr_en = (state == ACCESS) && (rw_q == MEM_RW_STORE) && !CLR;

    // Stall the pipeline from the capture cycle through the last byte cycle
    assign Rsp_Busy = ((state == IDLE) && Req_Enable) || (state == ACCESS);

`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic err_q;
    assign Rsp_Error = err_q;
`else
    assign Rsp_Error = 1'b0;
`endif

    data_mem_byte_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (CLK),
        .wr_en   (wr_en),
        .addr    (cur_addr),
        .wr_data (wr_byte),
        .rd_data (rd_byte)
    );

    // Request capture, byte sequencing, load assembly and completion flags
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state     <= IDLE;
            byte_cnt  <= 2'd0;
            last_idx  <= 2'd0;
            base_addr <= '0;
            rw_q      <= MEM_RW_LOAD;
            st_data   <= 32'd0;
            asm_data  <= 32'd0;
            Rsp_Data  <= 32'd0;
            Rsp_Done  <= 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    Rsp_Done <= 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
                    err_q    <= 1'b0;
`endif
                    if (Req_Enable) begin
                        byte_cnt  <= 2'd0;
                        last_idx  <= size_last_idx(Req_Size);
                        base_addr <= Req_Addr[ADDR_W-1:0];
                        rw_q      <= Req_RW;
                        st_data   <= Req_Data;
                        asm_data  <= 32'd0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
                        if (is_misaligned(Req_Size, Req_Addr[1:0])) begin
                            state    <= DONE;
                            Rsp_Done <= 1'b1;
                            err_q    <= 1'b1;
                        end else begin
                            state    <= ACCESS;
                        end
`else
                        state <= ACCESS;
`endif
                    end
                end
                ACCESS: begin
                    if (rw_q == MEM_RW_LOAD) begin
                        asm_data <= {asm_data[23:0], rd_byte};
                    end
                    if (last_byte) begin
                        state    <= DONE;
                        Rsp_Done <= 1'b1;
                        byte_cnt <= 2'd0;
                        if (rw_q == MEM_RW_LOAD) begin
                            Rsp_Data <= {asm_data[23:0], rd_byte};
                        end
                    end else begin
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    Rsp_Done <= 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
                    err_q    <= 1'b0;
`endif
                end
                default: begin
                    state    <= IDLE;
                    Rsp_Done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    logic        CLK;
    logic        CLR;
    logic        Req_Enable;
    logic        Req_RW;
    logic [1:0]  Req_Size;
    logic [31:0] Req_Addr;
    logic [31:0] Req_Data;
    logic [31:0] Rsp_Data;
    logic        Rsp_Busy;
    logic        Rsp_Done;
    logic        Rsp_Error;

    int n_checks = 0;
    int n_errors = 0;

    data_mem_responder #(.DEPTH(256), .ADDR_W(8)) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .Req_Enable (Req_Enable),
        .Req_RW     (Req_RW),
        .Req_Size   (Req_Size),
        .Req_Addr   (Req_Addr),
        .Req_Data   (Req_Data),
        .Rsp_Data   (Rsp_Data),
        .Rsp_Busy   (Rsp_Busy),
        .Rsp_Done   (Rsp_Done),
        .Rsp_Error  (Rsp_Error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives a request at a falling edge and watches it until Rsp_Done (bounded).
    // Cycle 1 is the capture cycle. Req_Enable is left high on return (still in DONE).
    task automatic run_req(input logic rw, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] data, output int done_cyc, output int busy_cnt,
                           output logic err_at_done, output logic busy_at_done,
                           output logic [31:0] data_at_done);
        @(negedge CLK);
        Req_Enable = 1'b1;
        Req_RW     = rw;
        Req_Size   = size;
        Req_Addr   = addr;
        Req_Data   = data;
        done_cyc     = 0;
        busy_cnt     = 0;
        err_at_done  = 1'b0;
        busy_at_done = 1'b0;
        data_at_done = 32'd0;
        for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
            if (cyc > 1) @(negedge CLK);
            #1;
            if (Rsp_Busy) busy_cnt++;
            if (Rsp_Done) begin
                done_cyc     = cyc;
                err_at_done  = Rsp_Error;
                busy_at_done = Rsp_Busy;
                data_at_done = Rsp_Data;
            end
        end
    endtask

    task automatic drop_req();
        @(negedge CLK);
        Req_Enable = 1'b0;
    endtask

    int          dc;
    int          bc;
    logic        er;
    logic        bd;
    logic [31:0] rd;
    logic        done_seen;

    initial begin
        CLR        = 1'b1;
        Req_Enable = 1'b0;
        Req_RW     = 1'b0;
        Req_Size   = 2'b00;
        Req_Addr   = 32'd0;
        Req_Data   = 32'd0;
        repeat (2) @(negedge CLK);
        CLR = 1'b0;
        #1;
        check("reset_busy",  32'(Rsp_Busy),  32'd0);
        check("reset_done",  32'(Rsp_Done),  32'd0);
        check("reset_error", 32'(Rsp_Error), 32'd0);
        check("reset_data",  Rsp_Data,       32'd0);
        check("reset_state", 32'(dut.state), 32'(IDLE));

        dut.u_array.Mem[8'h08] = 8'h55;
        dut.u_array.Mem[8'h09] = 8'h66;
        dut.u_array.Mem[8'h0A] = 8'h77;
        dut.u_array.Mem[8'h0B] = 8'h88;
        for (int i = 16; i < 20; i++) dut.u_array.Mem[i] = 8'hEE;
        dut.u_array.Mem[8'hFE] = 8'h00;
        dut.u_array.Mem[8'hFF] = 8'h00;
        dut.u_array.Mem[8'h00] = 8'h00;
        dut.u_array.Mem[8'h01] = 8'h00;

        // Word store, big-endian
        run_req(MEM_RW_STORE, MEM_SIZE_WORD, 32'h04, 32'hAABBCCDD, dc, bc, er, bd, rd);
        drop_req();
        check("wst_done_cyc", 32'(dc), 32'd6);
        check("wst_busy_cnt", 32'(bc), 32'd5);
        check("wst_err",      32'(er), 32'd0);
        check("wst_mem4", 32'(dut.u_array.Mem[8'h04]), 32'hAA);
        check("wst_mem5", 32'(dut.u_array.Mem[8'h05]), 32'hBB);
        check("wst_mem6", 32'(dut.u_array.Mem[8'h06]), 32'hCC);
        check("wst_mem7", 32'(dut.u_array.Mem[8'h07]), 32'hDD);
        check("wst_rsp_data_kept", Rsp_Data, 32'd0);

        // Word load
        run_req(MEM_RW_LOAD, MEM_SIZE_WORD, 32'h04, 32'h0, dc, bc, er, bd, rd);
        drop_req();
        check("wld_data",     rd,      32'hAABBCCDD);
        check("wld_done_cyc", 32'(dc), 32'd6);
        check("wld_busy_cnt", 32'(bc), 32'd5);

        // Byte load
        run_req(MEM_RW_LOAD, MEM_SIZE_BYTE, 32'h06, 32'h0, dc, bc, er, bd, rd);
        drop_req();
        check("bld_data",     rd,      32'h000000CC);
        check("bld_done_cyc", 32'(dc), 32'd3);
        check("bld_busy_cnt", 32'(bc), 32'd2);

        // Halfword load
        run_req(MEM_RW_LOAD, MEM_SIZE_HALF, 32'h04, 32'h0, dc, bc, er, bd, rd);
        drop_req();
        check("hld_data",     rd,      32'h0000AABB);
        check("hld_done_cyc", 32'(dc), 32'd4);

        // Size 11 load, then Req_Enable held across DONE with a new address
        run_req(MEM_RW_LOAD, 2'b11, 32'h04, 32'h0, dc, bc, er, bd, rd);
        check("s11_data",         rd,      32'hAABBCCDD);
        check("s11_done_cyc",     32'(dc), 32'd6);
        check("s11_busy_in_done", 32'(bd), 32'd0);
        Req_Addr = 32'h08;
        run_req(MEM_RW_LOAD, 2'b11, 32'h08, 32'h0, dc, bc, er, bd, rd);
        drop_req();
        check("b2b_done_cyc", 32'(dc), 32'd6);
        check("b2b_data",     rd,      32'h55667788);

        // Misaligned word store straddling the top of the array
        run_req(MEM_RW_STORE, MEM_SIZE_WORD, 32'hFE, 32'h11223344, dc, bc, er, bd, rd);
        drop_req();
`ifdef DATA_MEM_ALIGN_CHECK_EN
        check("mis_done_cyc", 32'(dc), 32'd2);
        check("mis_err",      32'(er), 32'd1);
        check("mis_busy_cnt", 32'(bc), 32'd1);
        check("mis_memFE", 32'(dut.u_array.Mem[8'hFE]), 32'h00);
        check("mis_memFF", 32'(dut.u_array.Mem[8'hFF]), 32'h00);
        check("mis_mem00", 32'(dut.u_array.Mem[8'h00]), 32'h00);
        check("mis_mem01", 32'(dut.u_array.Mem[8'h01]), 32'h00);
`else
        check("wrap_done_cyc", 32'(dc), 32'd6);
        check("wrap_err",      32'(er), 32'd0);
        check("wrap_memFE", 32'(dut.u_array.Mem[8'hFE]), 32'h11);
        check("wrap_memFF", 32'(dut.u_array.Mem[8'hFF]), 32'h22);
        check("wrap_mem00", 32'(dut.u_array.Mem[8'h00]), 32'h33);
        check("wrap_mem01", 32'(dut.u_array.Mem[8'h01]), 32'h44);
`endif
        check("st_rsp_data_kept", rd, 32'h55667788);

        // CLR during the second ACCESS cycle of a word store
        @(negedge CLK);
        Req_Enable = 1'b1;
        Req_RW     = MEM_RW_STORE;
        Req_Size   = MEM_SIZE_WORD;
        Req_Addr   = 32'h10;
        Req_Data   = 32'hCAFEBABE;
        @(negedge CLK);
        @(negedge CLK);
        CLR        = 1'b1;
        Req_Enable = 1'b0;
        @(negedge CLK);
        CLR = 1'b0;
        #1;
        check("clr_state", 32'(dut.state), 32'(IDLE));
        check("clr_busy",  32'(Rsp_Busy),  32'd0);
        check("clr_done",  32'(Rsp_Done),  32'd0);
        check("clr_err",   32'(Rsp_Error), 32'd0);
        check("clr_data",  Rsp_Data,       32'd0);
        done_seen = Rsp_Done;
        repeat (6) begin
            @(negedge CLK);
            #1;
            done_seen = done_seen | Rsp_Done;
        end
        check("clr_no_done", 32'(done_seen), 32'd0);
        check("clr_mem10", 32'(dut.u_array.Mem[8'h10]), 32'hCA);
        check("clr_mem11", 32'(dut.u_array.Mem[8'h11]), 32'hEE);
        check("clr_mem12", 32'(dut.u_array.Mem[8'h12]), 32'hEE);
        check("clr_mem13", 32'(dut.u_array.Mem[8'h13]), 32'hEE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
